// File: rtl/regfile_dump_reader.sv
// Walks an inclusive register range through one regFile read port and streams
// each register value out over a valid/ready interface.
module regfile_dump_reader #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic [4:0]   first_reg_i,
  input  logic [4:0]   last_reg_i,
  input  logic         abort_i,
  output logic [4:0]   Read_Register_o,
  input  logic [N-1:0] Read_Data_i,
  output logic         dump_valid_o,
  input  logic         dump_ready_i,
  output logic [N-1:0] dump_data_o,
  output logic [4:0]   dump_addr_o,
  output logic         dump_last_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o
);

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

  state_t     state;
  logic [4:0] last_reg;

  // Read_Register_o doubles as the walking address; it is cleared on every
  // return to IDLE so the read port is released.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      last_reg        <= '0;
      Read_Register_o <= '0;
      dump_valid_o    <= 1'b0;
      dump_data_o     <= '0;
      dump_addr_o     <= '0;
      dump_last_o     <= 1'b0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      err_o           <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            if (first_reg_i <= last_reg_i) begin
              last_reg        <= last_reg_i;
              Read_Register_o <= first_reg_i;
              busy_o          <= 1'b1;
              state           <= READ;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        READ: begin
          if (abort_i) begin
            Read_Register_o <= '0;
            busy_o          <= 1'b0;
            state           <= IDLE;
          end else begin
            dump_data_o  <= Read_Data_i;
            dump_addr_o  <= Read_Register_o;
            dump_last_o  <= (Read_Register_o == last_reg);
            dump_valid_o <= 1'b1;
            state        <= SEND;
          end
        end
        SEND: begin
          // Abort wins over a simultaneous handshake: that beat is dropped.
          if (abort_i) begin
            dump_valid_o    <= 1'b0;
            Read_Register_o <= '0;
            busy_o          <= 1'b0;
            state           <= IDLE;
          end else if (dump_ready_i) begin
            dump_valid_o <= 1'b0;
            if (dump_last_o) begin
              done_o <= 1'b1;
              state  <= DONE;
            end else begin
              Read_Register_o <= Read_Register_o + 5'd1;
              state           <= READ;
            end
          end
        end
        DONE: begin
          Read_Register_o <= '0;
          busy_o          <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomized bench for regfile_dump_reader: a register-array model feeds the read
// port and every streamed beat is compared against the expected address walk.
module tb_regfile_dump_reader;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_i;
  logic [4:0]   first_reg_i;
  logic [4:0]   last_reg_i;
  logic         abort_i;
  logic [4:0]   Read_Register_o;
  logic [N-1:0] Read_Data_i;
  logic         dump_valid_o;
  logic         dump_ready_i;
  logic [N-1:0] dump_data_o;
  logic [4:0]   dump_addr_o;
  logic         dump_last_o;
  logic         busy_o;
  logic         done_o;
  logic         err_o;

  logic [N-1:0] regs [32];

  int checks = 0;
  int errors = 0;

  logic [4:0]   q_addr[$];
  logic [N-1:0] q_data[$];
  bit           q_last[$];
  int done_cnt, err_cnt, valid_cnt, busy_cnt, done_at, last_hs, cyc;

  regfile_dump_reader #(.N(N)) dut (
    .clk(clk), .reset(reset), .start_i(start_i),
    .first_reg_i(first_reg_i), .last_reg_i(last_reg_i), .abort_i(abort_i),
    .Read_Register_o(Read_Register_o), .Read_Data_i(Read_Data_i),
    .dump_valid_o(dump_valid_o), .dump_ready_i(dump_ready_i),
    .dump_data_o(dump_data_o), .dump_addr_o(dump_addr_o),
    .dump_last_o(dump_last_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  assign Read_Data_i = regs[Read_Register_o];

  always #5 clk = ~clk;

  task automatic clear_obs();
    q_addr.delete(); q_data.delete(); q_last.delete();
    done_cnt = 0; err_cnt = 0; valid_cnt = 0; busy_cnt = 0;
    done_at = -1; last_hs = -1;
  endtask

  // Called at a negedge with inputs already driven: records what the next edge sees.
  task automatic tick();
    if (dump_valid_o && dump_ready_i && !abort_i && reset) begin
      q_addr.push_back(dump_addr_o);
      q_data.push_back(dump_data_o);
      q_last.push_back(dump_last_o);
      last_hs = cyc;
    end
    if (done_o) begin
      done_cnt++;
      if (done_at < 0) done_at = cyc;
    end
    if (err_o) err_cnt++;
    if (dump_valid_o) valid_cnt++;
    if (busy_o) busy_cnt++;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_start(input logic [4:0] f, input logic [4:0] l);
    cyc = 0;
    start_i = 1'b1; first_reg_i = f; last_reg_i = l;
    tick();
    start_i = 1'b0;
  endtask

  task automatic run(input int stall, input int abort_addr, input int inj_cyc,
                     input logic [4:0] inj_f, input logic [4:0] inj_l, input int budget);
    int held = 0;
    bit pstall = 0;
    logic [N-1:0] pd = '0;
    logic [4:0] pa = '0;
    logic pl = 1'b0;
    for (int n = 0; ; n++) begin
      if (n >= budget) begin
        checks++; errors++;
        $display("[TB] FAIL run_budget busy=%0b after %0d cycles, want idle", busy_o, budget);
        break;
      end
      if (pstall) begin
        checks++;
        if (dump_valid_o !== 1'b1 || dump_data_o !== pd || dump_addr_o !== pa || dump_last_o !== pl) begin
          errors++;
          $display("[TB] FAIL hold_stable got v=%0b a=%0d d=%h l=%0b want v=1 a=%0d d=%h l=%0b",
                   dump_valid_o, dump_addr_o, dump_data_o, dump_last_o, pa, pd, pl);
        end
      end
      abort_i = 1'b0;
      start_i = (cyc == inj_cyc);
      first_reg_i = inj_f; last_reg_i = inj_l;
      if (dump_valid_o) begin
        if (held < stall) begin dump_ready_i = 1'b0; held++; end
        else dump_ready_i = 1'b1;
      end else begin
        dump_ready_i = (stall == 0);
      end
      if (abort_addr >= 0 && dump_valid_o && int'(dump_addr_o) == abort_addr) begin
        abort_i = 1'b1; dump_ready_i = 1'b1;
      end
      pstall = dump_valid_o && !dump_ready_i;
      pd = dump_data_o; pa = dump_addr_o; pl = dump_last_o;
      if (dump_valid_o && dump_ready_i) held = 0;
      tick();
      if (abort_i) break;
      if (!busy_o) break;
    end
    start_i = 1'b0; abort_i = 1'b0;
  endtask

  // Starts a dump of f..l and compares the beat stream with the expected walk.
  task automatic test_dump_range(input int f, input int l, input int stall, input string tag);
    int n = l - f + 1;
    clear_obs();
    do_start(f[4:0], l[4:0]);
    run(stall, -1, -1, 5'd0, 5'd0, 2000);
    checks++;
    if (q_addr.size() !== n) begin
      errors++;
      $display("[TB] FAIL %s beat_count got %0d want %0d", tag, q_addr.size(), n);
    end
    for (int i = 0; i < n && i < q_addr.size(); i++) begin
      int a = f + i;
      checks++;
      if (int'(q_addr[i]) != a || q_data[i] !== regs[a] || q_last[i] != (a == l)) begin
        errors++;
        $display("[TB] FAIL %s beat%0d got a=%0d d=%h l=%0b want a=%0d d=%h l=%0b",
                 tag, i, q_addr[i], q_data[i], q_last[i], a, regs[a], (a == l));
      end
    end
    checks++;
    if (done_cnt !== 1 || done_at !== last_hs + 1) begin
      errors++;
      $display("[TB] FAIL %s done got count=%0d at=%0d want count=1 at=%0d", tag, done_cnt, done_at, last_hs + 1);
    end
    if (stall == 0) begin
      checks++;
      if (done_at !== 2 * n + 1) begin
        errors++;
        $display("[TB] FAIL %s dump_length got %0d want %0d", tag, done_at, 2 * n + 1);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    checks++;
    if ({Read_Register_o, dump_valid_o, dump_data_o, dump_addr_o, dump_last_o, busy_o, done_o, err_o} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got rr=%0d v=%0b d=%h a=%0d l=%0b b=%0b dn=%0b e=%0b want all 0",
               Read_Register_o, dump_valid_o, dump_data_o, dump_addr_o, dump_last_o, busy_o, done_o, err_o);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_full_dump();
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? '0 : N'(32'h100 + i);
    test_dump_range(0, 31, 0, "full_dump");
  endtask

  task automatic test_backpressure();
    test_dump_range(10, 12, 3, "backpressure");
  endtask

  task automatic test_degenerate();
    test_dump_range(4, 4, 0, "single_reg");
    clear_obs();
    do_start(5'd7, 5'd3);
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL err_pulse got %0b want 1", err_o);
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (err_cnt !== 1 || busy_cnt !== 0 || valid_cnt !== 0) begin
      errors++;
      $display("[TB] FAIL bad_range got err=%0d busy=%0d valid=%0d want 1 0 0", err_cnt, busy_cnt, valid_cnt);
    end
  endtask

  task automatic test_abort();
    clear_obs();
    do_start(5'd0, 5'd31);
    run(0, 5, -1, 5'd0, 5'd0, 200);
    checks++;
    if (busy_o !== 1'b0 || dump_valid_o !== 1'b0 || Read_Register_o !== 5'd0) begin
      errors++;
      $display("[TB] FAIL abort_idle got busy=%0b v=%0b rr=%0d want 0 0 0", busy_o, dump_valid_o, Read_Register_o);
    end
    tick(); tick();
    checks++;
    if (q_addr.size() !== 5 || done_cnt !== 0) begin
      errors++;
      $display("[TB] FAIL abort_beats got beats=%0d done=%0d want 5 0", q_addr.size(), done_cnt);
    end
    test_dump_range(0, 1, 0, "after_abort");
  endtask

  task automatic test_reset_mid_dump();
    int n = 0;
    clear_obs();
    do_start(5'd0, 5'd31);
    dump_ready_i = 1'b1;
    while (!(busy_o && !dump_valid_o && Read_Register_o == 5'd2) && n < 40) begin
      tick(); n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("[TB] FAIL reach_read2 got rr=%0d want 2", Read_Register_o);
    end
    reset = 1'b0; start_i = 1'b1; first_reg_i = 5'd5; last_reg_i = 5'd6;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({Read_Register_o, dump_valid_o, dump_data_o, dump_addr_o, dump_last_o, busy_o, done_o, err_o} !== '0) begin
        errors++;
        $display("[TB] FAIL mid_reset%0d got rr=%0d v=%0b d=%h a=%0d b=%0b want all 0",
                 i, Read_Register_o, dump_valid_o, dump_data_o, dump_addr_o, busy_o);
      end
    end
    reset = 1'b1; start_i = 1'b0;
    tick(); tick();
    checks++;
    if (busy_o !== 1'b0 || dump_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle got busy=%0b v=%0b want 0 0", busy_o, dump_valid_o);
    end
    test_dump_range(3, 5, 1, "after_reset");
  endtask

  task automatic test_start_while_busy();
    clear_obs();
    do_start(5'd0, 5'd3);
    run(0, -1, 3, 5'd20, 5'd21, 200);
    checks++;
    if (q_addr.size() !== 4 || done_cnt !== 1) begin
      errors++;
      $display("[TB] FAIL busy_start got beats=%0d done=%0d want 4 1", q_addr.size(), done_cnt);
    end
    for (int i = 0; i < 4 && i < q_addr.size(); i++) begin
      checks++;
      if (int'(q_addr[i]) != i || q_data[i] !== regs[i] || q_last[i] != (i == 3)) begin
        errors++;
        $display("[TB] FAIL busy_start_beat%0d got a=%0d d=%h want a=%0d d=%h", i, q_addr[i], q_data[i], i, regs[i]);
      end
    end
    clear_obs();
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (busy_cnt !== 0 || valid_cnt !== 0) begin
      errors++;
      $display("[TB] FAIL no_second_dump got busy=%0d valid=%0d want 0 0", busy_cnt, valid_cnt);
    end
  endtask

  task automatic test_random_ranges();
    for (int it = 0; it < 5; it++) begin
      int f, l, s;
      for (int i = 1; i < 32; i++) regs[i] = N'($urandom);
      regs[0] = '0;
      f = $urandom_range(0, 31);
      l = $urandom_range(f, 31);
      s = $urandom_range(0, 2);
      test_dump_range(f, l, s, "random");
    end
  endtask

  initial begin
    start_i = 1'b0; abort_i = 1'b0; dump_ready_i = 1'b0;
    first_reg_i = '0; last_reg_i = '0; reset = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    cyc = 0;
    clear_obs();
    @(negedge clk);
    test_reset();
    test_full_dump();
    test_backpressure();
    test_degenerate();
    test_abort();
    test_reset_mid_dump();
    test_start_while_busy();
    test_random_ranges();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
